// File: rtl/vector_memory_unit_if.sv
// Bundle of pipeline-side and data-memory-side signals of the vector memory stage.
// The slave modport is the memory unit; the master modport is its environment (EX/MEM register plus data memory).
interface vector_memory_unit_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int VECTOR_SIZE = 6,
  parameter int ADDR_WIDTH  = 8
);
  localparam int VEC_WIDTH = DATA_WIDTH * VECTOR_SIZE;

  logic                  start;
  logic                  isLoad;
  logic                  isStore;
  logic                  isVector;
  logic [VEC_WIDTH-1:0]  aluResult;
  logic [VEC_WIDTH-1:0]  writeData;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic                  memWriteEnable;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic [DATA_WIDTH-1:0] memReadData;
  logic                  stall;
  logic [VEC_WIDTH-1:0]  result;
  logic                  resultValid;

  modport master (
    output start, isLoad, isStore, isVector, aluResult, writeData, memReadData,
    input  memAddress, memWriteEnable, memWriteData, stall, result, resultValid
  );

  modport slave (
    input  start, isLoad, isStore, isVector, aluResult, writeData, memReadData,
    output memAddress, memWriteEnable, memWriteData, stall, result, resultValid
  );
endinterface

// File: rtl/vector_memory_unit.sv
// Memory stage: serialises scalar/vector loads and stores onto a byte-wide synchronous
// data memory port, stalls the pipeline while busy and delivers load data or the ALU result.
module vector_memory_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int VECTOR_SIZE = 6,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  vector_memory_unit_if.slave bus
);
  localparam int VEC_WIDTH = DATA_WIDTH * VECTOR_SIZE;
  localparam int K_WIDTH   = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [K_WIDTH-1:0]    k_q, k_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [VEC_WIDTH-1:0]  wdata_q, wdata_d;
  logic                  vec_q, vec_d;
  logic                  load_q, load_d;
  logic [VEC_WIDTH-1:0]  result_q, result_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d;

  logic                  mem_op;
  logic [K_WIDTH-1:0]    last_k;
  logic [K_WIDTH-1:0]    prev_k;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  stall;

  assign mem_op    = bus.isLoad | bus.isStore;
  assign last_k    = vec_q ? K_WIDTH'(VECTOR_SIZE - 1) : '0;
  assign prev_k    = k_q - 1'b1;
  assign beat_addr = base_q + ADDR_WIDTH'(k_q);
  assign beat_data = wdata_q[int'(k_q)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    k_d       = k_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    vec_d     = vec_q;
    load_d    = load_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    addr_d    = addr_q;
    mwdata_d  = mwdata_q;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = mwdata_q;
    stall     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && mem_op) begin
          stall    = 1'b1;
          state_d  = ACCESS;
          k_d      = '0;
          base_d   = bus.aluResult[ADDR_WIDTH-1:0];
          wdata_d  = bus.writeData;
          vec_d    = bus.isVector;
          load_d   = bus.isLoad;
          // Loads start from zero so a scalar load leaves the upper lanes clear.
          result_d = bus.isLoad ? '0 : bus.aluResult;
        end else if (bus.start) begin
          result_d = bus.aluResult;
          valid_d  = 1'b1;
        end
      end

      ACCESS: begin
        stall    = 1'b1;
        mem_addr = beat_addr;
        addr_d   = beat_addr;
        if (!load_q) begin
          mem_we    = 1'b1;
          mem_wdata = beat_data;
          mwdata_d  = beat_data;
        end else if (k_q != '0) begin
          // Read data lags the address by one cycle, so this beat returns the previous lane.
          result_d[int'(prev_k)*DATA_WIDTH +: DATA_WIDTH] = bus.memReadData;
        end
        if (k_q == last_k) begin
          state_d = load_q ? DRAIN : IDLE;
          valid_d = !load_q;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      DRAIN: begin
        stall = 1'b1;
        result_d[int'(last_k)*DATA_WIDTH +: DATA_WIDTH] = bus.memReadData;
        state_d = IDLE;
        valid_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      vec_q    <= 1'b0;
      load_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      vec_q    <= vec_d;
      load_q   <= load_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Write strobe decodes straight from the state flop, so reset kills it without waiting for a clock.
  assign bus.memAddress     = mem_addr;
  assign bus.memWriteEnable = mem_we;
  assign bus.memWriteData   = mem_wdata;
  assign bus.stall          = stall;
  assign bus.result         = result_q;
  assign bus.resultValid    = valid_q;
endmodule

// File: tb/tb_vector_memory_unit.sv
// Self-checking bench for vector_memory_unit: directed table, hand-written corner sequences
// and randomized instructions checked against an array-based memory model.
module tb_vector_memory_unit;
  typedef struct {
    bit          load;
    bit          store;
    bit          vec;
    logic [47:0] alu;
    logic [47:0] wdata;
  } op_t;

  typedef struct {
    string       name;
    op_t         op;
    logic [47:0] exp_res;
    int          exp_st;
    int          exp_lat;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [7:0]  dev_mem [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  rd_q;
  logic [15:0] wr_log [$];

  vector_memory_unit_if bus ();

  vector_memory_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte-wide data memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (bus.memWriteEnable) dev_mem[bus.memAddress] <= bus.memWriteData;
    rd_q <= dev_mem[bus.memAddress];
  end
  assign bus.memReadData = rd_q;

  always @(negedge clk) begin
    if (bus.memWriteEnable) wr_log.push_back({bus.memAddress, bus.memWriteData});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] rand48();
    return 48'({$urandom(), $urandom()});
  endfunction

  // Reference behaviour from the instruction-level rules; updates the model memory for stores.
  task automatic model(input op_t op, output logic [47:0] res, output int st, output int lat);
    int         n;
    logic [7:0] a;
    n = op.vec ? 6 : 1;
    res = '0;
    if (!(op.load || op.store)) begin
      res = op.alu; st = 0; lat = 1;
    end else if (op.load) begin
      for (int k = 0; k < n; k++) begin
        a = op.alu[7:0] + 8'(k);
        res[k*8 +: 8] = ref_mem[a];
      end
      st = n + 2; lat = n + 2;
    end else begin
      for (int k = 0; k < n; k++) begin
        a = op.alu[7:0] + 8'(k);
        ref_mem[a] = op.wdata[k*8 +: 8];
      end
      res = op.alu; st = n + 1; lat = n + 1;
    end
  endtask

  task automatic drive_op(input op_t op);
    bus.start     = 1'b1;
    bus.isLoad    = op.load;
    bus.isStore   = op.store;
    bus.isVector  = op.vec;
    bus.aluResult = op.alu;
    bus.writeData = op.wdata;
  endtask

  // Issues one instruction at the current cycle (called at posedge+1) and checks it to completion.
  task automatic run_op(input string name, input op_t op, input bit use_exp,
                        input logic [47:0] t_res, input int t_st, input int t_lat, input bit junk);
    logic [47:0] m_res, exp_res, res;
    int          m_st, m_lat, exp_st, exp_lat, st, lat, n;
    logic [7:0]  a;
    model(op, m_res, m_st, m_lat);
    exp_res = use_exp ? t_res : m_res;
    exp_st  = use_exp ? t_st  : m_st;
    exp_lat = use_exp ? t_lat : m_lat;
    wr_log.delete();
    drive_op(op);
    st = 0; lat = -1; res = '0;
    for (int c = 0; c < 24 && lat < 0; c++) begin
      @(negedge clk);
      if (c > 0 && bus.resultValid) begin lat = c; res = bus.result; end
      if (bus.stall) st++;
      @(posedge clk); #1;
      if (junk && c + 1 < exp_st) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.isLoad    = 1'($urandom_range(0, 1));
        bus.isStore   = 1'($urandom_range(0, 1));
        bus.isVector  = 1'($urandom_range(0, 1));
        bus.aluResult = rand48();
        bus.writeData = rand48();
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_stall"}, 64'(st), 64'(exp_st));
    check({name, "_result"}, 64'(res), 64'(exp_res));
    n = op.vec ? 6 : 1;
    if (op.store && !op.load) begin
      check({name, "_wr_count"}, 64'(wr_log.size()), 64'(n));
      for (int k = 0; k < n && k < wr_log.size(); k++) begin
        a = op.alu[7:0] + 8'(k);
        check({name, "_wr_addr"}, 64'(wr_log[k][15:8]), 64'(a));
        check({name, "_wr_data"}, 64'(wr_log[k][7:0]), 64'(op.wdata[k*8 +: 8]));
      end
    end else begin
      check({name, "_wr_count"}, 64'(wr_log.size()), 64'd0);
    end
    wr_log.delete();
  endtask

  initial begin
    vec_t        tbl [10];
    op_t         op;
    logic [47:0] m_res, r1, r2;
    int          m_st, m_lat, first, second;
    bit          rv_seen;

    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end

    tbl[0] = '{"nonmem_42",   '{0, 0, 0, 48'h0000_0000_0042, 48'h0},              48'h0000_0000_0042, 0, 1};
    tbl[1] = '{"vst_10",      '{0, 1, 1, 48'h0000_0000_0010, 48'h0605_0403_0201}, 48'h0000_0000_0010, 7, 7};
    tbl[2] = '{"vld_10",      '{1, 0, 1, 48'h0000_0000_0010, 48'h0},              48'h0605_0403_0201, 8, 8};
    tbl[3] = '{"sst_ff",      '{0, 1, 0, 48'h0000_0000_00FF, 48'h0000_0000_00AB}, 48'h0000_0000_00FF, 2, 2};
    tbl[4] = '{"sld_ff",      '{1, 0, 0, 48'h0000_0000_00FF, 48'h0},              48'h0000_0000_00AB, 3, 3};
    tbl[5] = '{"vst_fe_wrap", '{0, 1, 1, 48'h0000_0000_00FE, 48'h0C0B_0A09_0807}, 48'h0000_0000_00FE, 7, 7};
    tbl[6] = '{"vld_fe_wrap", '{1, 0, 1, 48'h0000_0000_00FE, 48'h0},              48'h0C0B_0A09_0807, 8, 8};
    tbl[7] = '{"ldst_as_ld",  '{1, 1, 0, 48'h0000_0000_0012, 48'h0000_0000_00FF}, 48'h0000_0000_0003, 3, 3};
    tbl[8] = '{"nonmem_wide", '{0, 0, 1, 48'hABCD_1234_5678, 48'h1111_2222_3333}, 48'hABCD_1234_5678, 0, 1};
    tbl[9] = '{"sld_hi_bits", '{1, 0, 0, 48'h1234_5678_9A11, 48'h0},              48'h0000_0000_0002, 3, 3};

    reset = 1'b1;
    bus.start = 1'b0; bus.isLoad = 1'b0; bus.isStore = 1'b0; bus.isVector = 1'b0;
    bus.aluResult = '0; bus.writeData = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_memAddress", 64'(bus.memAddress), 64'd0);
    check("rst_memWriteEnable", 64'(bus.memWriteEnable), 64'd0);
    check("rst_memWriteData", 64'(bus.memWriteData), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_resultValid", 64'(bus.resultValid), 64'd0);
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i].name, tbl[i].op, 1'b1, tbl[i].exp_res, tbl[i].exp_st, tbl[i].exp_lat, 1'b0);

    // Back-to-back: a non-memory op waits on start and is taken in the load's result cycle.
    op = '{1, 0, 1, 48'h0000_0000_0010, 48'h0};
    model(op, m_res, m_st, m_lat);
    drive_op(op);
    @(posedge clk); #1;
    drive_op('{0, 0, 0, 48'h0000_0000_0077, 48'h0});
    first = -1; second = -1; r1 = '0; r2 = '0;
    for (int c = 1; c < 24 && second < 0; c++) begin
      @(negedge clk);
      if (bus.resultValid) begin
        if (first < 0) begin first = c; r1 = bus.result; end
        else begin second = c; r2 = bus.result; end
      end
      @(posedge clk); #1;
      if (first >= 0) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    check("b2b_first_cycle", 64'(first), 64'(m_lat));
    check("b2b_second_cycle", 64'(second), 64'(m_lat + 1));
    check("b2b_first_result", 64'(r1), 64'(m_res));
    check("b2b_second_result", 64'(r2), 64'h77);

    // Reset in the third write cycle of a vector store at 0x40.
    wr_log.delete();
    drive_op('{0, 1, 1, 48'h0000_0000_0040, 48'h6655_4433_2211});
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_we_before", 64'(bus.memWriteEnable), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_we_async", 64'(bus.memWriteEnable), 64'd0);
    check("midrst_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    rv_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.resultValid) rv_seen = 1'b1;
    end
    check("midrst_no_valid", 64'(rv_seen), 64'd0);
    check("midrst_mem40", 64'(dev_mem[8'h40]), 64'h11);
    check("midrst_mem41", 64'(dev_mem[8'h41]), 64'h22);
    check("midrst_mem43", 64'(dev_mem[8'h43]), 64'h00);
    check("midrst_mem44", 64'(dev_mem[8'h44]), 64'h00);
    check("midrst_mem45", 64'(dev_mem[8'h45]), 64'h00);
    ref_mem[8'h40] = 8'h11;
    ref_mem[8'h41] = 8'h22;
    wr_log.delete();
    @(posedge clk); #1;
    run_op("post_rst_vld", '{1, 0, 1, 48'h0000_0000_0040, 48'h0}, 1'b0, '0, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      op.load  = (kind == 1) || (kind == 3);
      op.store = (kind == 2) || (kind == 3);
      op.vec   = 1'($urandom_range(0, 1));
      op.alu   = rand48();
      op.wdata = rand48();
      if ($urandom_range(0, 1) == 1) op.alu[7:0] = 8'($urandom_range(8'hF8, 8'hFF) + $urandom_range(0, 20));
      run_op("rand", op, 1'b0, '0, 0, 0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_memory_unit.md
# vector_memory_unit

Memory stage sitting directly downstream of the execute stage: consumes the execute result (`out`, used as the address for memory ops) and the store operand (`dataToWrite`). Serialises scalar and vector loads/stores onto a single byte-wide data memory port and stalls the pipeline while busy. Delivers the load data, or the passed-through ALU result, to write-back and to the M-stage forward path.

## Interface
Parameters:
- `DATA_WIDTH`, 8, lane/scalar width and memory data width.
- `VECTOR_SIZE`, 6, lanes per vector.
- `ADDR_WIDTH`, 8, memory address width; taken from `aluResult[ADDR_WIDTH-1:0]`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  EX/MEM register holds a valid instruction this cycle.
- `isLoad`  in  1  memory read.
- `isStore`  in  1  memory write.
- `isVector`  in  1  access is `VECTOR_SIZE` lanes (1) or one lane (0).
- `aluResult`  in  DATA_WIDTH*VECTOR_SIZE  execute output; address source and pass-through result.
- `writeData`  in  DATA_WIDTH*VECTOR_SIZE  store data; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `memAddress`  out  ADDR_WIDTH  data memory address.
- `memWriteEnable`  out  1  data memory write strobe.
- `memWriteData`  out  DATA_WIDTH  data memory write data.
- `memReadData`  in  DATA_WIDTH  data memory read data; synchronous, valid the cycle after `memAddress`.
- `stall`  out  1  freeze fetch through EX/MEM.
- `result`  out  DATA_WIDTH*VECTOR_SIZE  value for write-back and forwarding.
- `resultValid`  out  1  `result` is valid this cycle (one-cycle pulse per accepted instruction).

## Operation
- Memory op means `isLoad | isStore`. If both are high, the instruction is treated as a load.
- Beat count N is `VECTOR_SIZE` if `isVector`, else 1.
- Lane k address is `base + k`, modulo 2^ADDR_WIDTH. Wrap-around is silent, e.g. base 0xFE, lane 2 → 0x00.
- FSM states:
  - IDLE: on `start` with a memory op, latch base address, `writeData`, N and op type; beat counter k←0; go to ACCESS. On `start` with a non-memory op, register `aluResult` into `result` with `resultValid`=1 next cycle; stay IDLE.
  - ACCESS: drive `memAddress`=base+k each cycle.
    - Store: `memWriteEnable`=1, `memWriteData`=lane k.
    - Load: `memWriteEnable`=0; capture `memReadData` into lane k-1 when k>0.
    - Counter: k++. At k=N-1, a store goes to IDLE (asserting `resultValid`) and a load goes to DRAIN.
  - DRAIN (loads only): capture `memReadData` into lane N-1; go to IDLE, asserting `resultValid`.
- Load result:
  - Vector: lane k = byte from base+k.
  - Scalar: lane 0 = byte, upper lanes zero.
  - Store result: latched `aluResult` (not written back; carried so `resultValid` still pulses).
- `stall` = (IDLE & `start` & memory op) | ACCESS | DRAIN. Combinational, so EX/MEM holds from the accept cycle.
- Outside ACCESS: `memWriteEnable`=0, and `memAddress` and `memWriteData` hold their last values.

## Timing
- Reset values: state IDLE, k=0, `result`=0, `resultValid`=0, `memAddress`=0, `memWriteData`=0, `memWriteEnable`=0, `stall`=0 (given `start`=0).
- Non-memory op accepted at T0: `resultValid` high at T1, no stall.
- Store accepted at T0:
  - `stall` high T0..T(N).
  - Writes occur in T1..T(N).
  - `resultValid` and IDLE at T(N+1).
  - Total N+1 stalled cycles.
- Load accepted at T0:
  - `stall` high T0..T(N+1).
  - Lane k is captured at the end of T(k+2).
  - `resultValid` at T(N+2).
- A new `start` may be accepted in the same cycle `resultValid` is high (back-to-back, no bubble).
- `start` during ACCESS/DRAIN is ignored; the pipeline is stalled, so EX/MEM still holds the accepted instruction.
- Reset mid-operation: immediately IDLE, `memWriteEnable` drops asynchronously, partial load data is discarded, and no `resultValid` is produced.

## Test plan
- Reset then idle → all outputs 0. Non-memory op with `aluResult`=0x0000_0000_0042 at T0 → `result`=0x42 and `resultValid`=1 at T1, `stall` never high.
- Vector store, base 0x10, `writeData` lanes 0..5 = 0x01..0x06 → writes 0x10←0x01 … 0x15←0x06 on T1..T6, `stall` high T0..T6, `resultValid` at T7.
- Vector load, base 0x10, with the memory preloaded from the previous test → `result`=0x06_05_04_03_02_01 at T8, `stall` high T0..T7.
- Scalar load from 0xFF holding 0xAB → `result`=0x0000_0000_00AB at T3. Vector store at base 0xFE → addresses 0xFE,0xFF,0x00,0x01,0x02,0x03.
- Back-to-back: vector load, then a non-memory op held on `start` → second `resultValid` exactly one cycle after the first.
- Assert `reset` during T3 of a vector store → `memWriteEnable` falls immediately, addresses base+3.. not written, `resultValid` stays 0, next op behaves normally.
